// File: rtl/pipe_stage_skid.sv
// Multi-lane valid/ready pipeline stage with a 2-entry skid buffer, lane kill and flush.
// Optional perf counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int LANES = 2,
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flash,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  input  logic [LANES-1:0]       kill_mask,
  output logic [1:0]             occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]       perf_stall_cnt,
  output logic [CNT_W-1:0]       perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [LANES-1:0]       skid_valid;
  logic [LANES*WIDTH-1:0] skid_data;

  logic                   acc, drn, killed_all, pop;
  logic [LANES-1:0]       kept, head_valid_nx;
  logic                   head_from_in, head_from_skid, skid_from_in;

  assign acc        = (|in_valid) & in_ready;
  assign drn        = (|out_valid) & out_ready;
  assign kept       = out_valid & ~kill_mask;
  // A kill that empties the head retires it exactly like a drain.
  assign killed_all = (|out_valid) & ~out_ready & ~(|kept);
  assign pop        = drn | killed_all;
  assign occupancy  = state;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx       = state;
    head_valid_nx  = kept;
    head_from_in   = 1'b0;
    head_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_nx     = ONE;
          head_from_in = 1'b1;
        end
      end
      ONE: begin
        if (acc && !pop) begin
          state_nx     = TWO;
          skid_from_in = 1'b1;
        end else if (acc && pop) begin
          head_from_in = 1'b1;
        end else if (pop) begin
          state_nx      = EMPTY;
          head_valid_nx = '0;
        end
      end
      TWO: begin
        if (pop) begin
          state_nx       = ONE;
          head_from_skid = 1'b1;
        end
      end
      default: begin
        state_nx      = EMPTY;
        head_valid_nx = '0;
      end
    endcase
    if (head_from_in)   head_valid_nx = in_valid;
    if (head_from_skid) head_valid_nx = skid_valid;
    if (flash) begin
      state_nx       = EMPTY;
      head_valid_nx  = '0;
      head_from_in   = 1'b0;
      head_from_skid = 1'b0;
      skid_from_in   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the payload
  // registers are reset too because out_data is defined as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= '0;
      out_data   <= '0;
      skid_valid <= '0;
      skid_data  <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != TWO);
      out_valid <= head_valid_nx;
      if (head_from_in)        out_data <= in_data;
      else if (head_from_skid) out_data <= skid_data;
      if (skid_from_in) begin
        skid_data  <= in_data;
        skid_valid <= in_valid;
      end else if (head_from_skid || flash) begin
        skid_valid <= '0;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if ((|out_valid) && !out_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if ((out_valid == '0) && (perf_bubble_cnt != '1))
        perf_bubble_cnt <= perf_bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
